// File: rtl/term_text_engine.sv
// Character-stream engine for the VGA text terminal: decodes printable and control
// bytes, tracks the cursor, scrolls a circular row buffer and drives the screen RAM write port.
module term_text_engine #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int ATTR_W    = 25,
    parameter int BLINK_DIV = 25_000_000,
    parameter int ADDR_W    = $clog2(COLS*ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                in_data,
    input  logic [ATTR_W-1:0]         in_attr,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_char,
    output logic [ATTR_W-1:0]         wr_attr,
    output logic [$clog2(ROWS)-1:0]   top_row,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic                      cursor_on,
    output logic [1:0]                dbgState
);

    localparam int RW    = $clog2(ROWS);
    localparam int RW1   = RW + 1;
    localparam int CW    = $clog2(COLS);
    localparam int TW    = CW + 4;
    localparam int CELLS = COLS * ROWS;
    localparam int NW    = ADDR_W + 1;
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [ATTR_W-1:0] ATTR_RST = ATTR_W'(28'h0000FFF);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and the source holds its byte until then.
    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        SCROLL = 2'd2
    } state_t;

    state_t              state, stateNext;
    logic [NW-1:0]       cnt, cntNext;
    logic [ADDR_W-1:0]   scrBase, scrBaseNext;
    logic [ATTR_W-1:0]   scrAttr, scrAttrNext;
    logic [RW-1:0]       rowNext, topNext, physRow, topInc;
    logic [RW:0]         rowSum;
    logic [CW-1:0]       colNext;
    logic [TW-1:0]       tabWide;
    logic [ADDR_W-1:0]   curAddr, wrAddrNext;
    logic [7:0]          wrCharNext;
    logic [ATTR_W-1:0]   wrAttrNext;
    logic                wrEnNext, advance, moved, isPrint;
    logic [BW-1:0]       blinkCnt, blinkCntNext;
    logic                cursorOnNext;

    assign in_ready = (state == IDLE);
    assign dbgState = state;

    // Logical row maps onto the circular buffer starting at top_row.
    always_comb begin
        rowSum  = {1'b0, cur_row} + {1'b0, top_row};
        physRow = (rowSum >= RW1'(ROWS)) ? RW'(rowSum - RW1'(ROWS)) : RW'(rowSum);
        curAddr = ADDR_W'(physRow) * ADDR_W'(COLS) + ADDR_W'(cur_col);
        topInc  = (top_row == RW'(ROWS-1)) ? '0 : top_row + 1'b1;
        tabWide = ({4'b0, cur_col} & ~TW'(7)) + TW'(8);
        isPrint = (in_data >= 8'h20) && (in_data <= 8'h7E);
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        scrBaseNext  = scrBase;
        scrAttrNext  = scrAttr;
        rowNext      = cur_row;
        colNext      = cur_col;
        topNext      = top_row;
        wrEnNext     = 1'b0;
        wrAddrNext   = wr_addr;
        wrCharNext   = wr_char;
        wrAttrNext   = wr_attr;
        advance      = 1'b0;
        moved        = 1'b0;
        blinkCntNext = blinkCnt;
        cursorOnNext = cursor_on;

        case (state)
            CLEAR: begin
                if (cnt == NW'(CELLS)) begin
                    stateNext = IDLE;
                end else begin
                    wrEnNext   = 1'b1;
                    wrAddrNext = cnt[ADDR_W-1:0];
                    wrCharNext = 8'h20;
                    wrAttrNext = ATTR_RST;
                    cntNext    = cnt + 1'b1;
                end
            end
            SCROLL: begin
                if (cnt == NW'(COLS)) begin
                    stateNext = IDLE;
                end else begin
                    wrEnNext   = 1'b1;
                    wrAddrNext = scrBase + cnt[ADDR_W-1:0];
                    wrCharNext = 8'h20;
                    wrAttrNext = scrAttr;
                    cntNext    = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (isPrint) begin
                        wrEnNext   = 1'b1;
                        wrAddrNext = curAddr;
                        wrCharNext = in_data;
                        wrAttrNext = in_attr;
                        if (cur_col == CW'(COLS-1)) begin
                            colNext = '0;
                            advance = 1'b1;
                        end else begin
                            colNext = cur_col + 1'b1;
                        end
                    end else begin
                        case (in_data)
                            8'h0D: colNext = '0;
                            8'h0A: advance = 1'b1;
                            8'h08: if (cur_col != '0) colNext = cur_col - 1'b1;
                            8'h09: colNext = (tabWide >= TW'(COLS)) ? CW'(COLS-1) : tabWide[CW-1:0];
                            8'h0C: begin
                                // Address 0 is written on entry, so the count resumes at 1.
                                stateNext  = CLEAR;
                                rowNext    = '0;
                                colNext    = '0;
                                topNext    = '0;
                                cntNext    = NW'(1);
                                wrEnNext   = 1'b1;
                                wrAddrNext = '0;
                                wrCharNext = 8'h20;
                                wrAttrNext = ATTR_RST;
                                moved      = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (advance) begin
                        if (cur_row != RW'(ROWS-1)) begin
                            rowNext = cur_row + 1'b1;
                        end else begin
                            // The old top row becomes the new bottom row and is blanked.
                            topNext     = topInc;
                            stateNext   = SCROLL;
                            cntNext     = '0;
                            scrBaseNext = ADDR_W'(top_row) * ADDR_W'(COLS);
                            scrAttrNext = in_attr;
                            moved       = 1'b1;
                        end
                    end
                end
            end
            default: stateNext = CLEAR;
        endcase

        if (moved || (rowNext != cur_row) || (colNext != cur_col)) begin
            blinkCntNext = '0;
            cursorOnNext = 1'b1;
        end else if (blinkCnt == BW'(BLINK_DIV-1)) begin
            blinkCntNext = '0;
            cursorOnNext = ~cursor_on;
        end else begin
            blinkCntNext = blinkCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            scrBase   <= '0;
            scrAttr   <= ATTR_RST;
            cur_row   <= '0;
            cur_col   <= '0;
            top_row   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_char   <= 8'h20;
            wr_attr   <= ATTR_RST;
            blinkCnt  <= '0;
            cursor_on <= 1'b1;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            scrBase   <= scrBaseNext;
            scrAttr   <= scrAttrNext;
            cur_row   <= rowNext;
            cur_col   <= colNext;
            top_row   <= topNext;
            wr_en     <= wrEnNext;
            wr_addr   <= wrAddrNext;
            wr_char   <= wrCharNext;
            wr_attr   <= wrAttrNext;
            blinkCnt  <= blinkCntNext;
            cursor_on <= cursorOnNext;
        end
    end

endmodule

// File: doc/term_text_engine.md
# term_text_engine

Parametrised character-stream engine for the VGA text terminal: accepts a byte stream over a valid/ready handshake, interprets printable characters and a small set of control codes, and drives the write port of the screen character/attribute RAM read by the VGA character renderer. It generalises the fixed-size terminal to any COLS×ROWS geometry and adds hardware cursor tracking, auto-wrap, circular-buffer scrolling, screen clear and cursor blink.

## Interface
- COLS, 80, characters per row (≥2)
- ROWS, 30, rows per screen (≥2)
- ATTR_W, 25, attribute width ({underline, bg[11:0], fg[11:0]})
- BLINK_DIV, 25_000_000, clock cycles per cursor blink half-period
- ADDR_W, derived $clog2(COLS*ROWS), RAM address width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  character/control byte
- in_attr  in  ATTR_W  attribute applied to printable bytes
- in_valid  in  1  byte present
- in_ready  out  1  engine can accept a byte
- wr_en  out  1  screen RAM write strobe
- wr_addr  out  ADDR_W  physical RAM address
- wr_char  out  8  character written
- wr_attr  out  ATTR_W  attribute written
- top_row  out  $clog2(ROWS)  physical row shown as screen row 0 (for renderer)
- cur_row  out  $clog2(ROWS)  cursor logical row
- cur_col  out  $clog2(COLS)  cursor column
- cursor_on  out  1  blink phase (1 = cursor drawn)

## Operation
- Physical row = (logical row + top_row) mod ROWS; wr_addr = phys_row*COLS + col. No wider-than-ADDR_W intermediate truncation errors permitted.
- States: CLEAR, IDLE, SCROLL. in_ready = 1 only in IDLE.
- Byte accepted when in_valid & in_ready. Decode:
  - 0x20–0x7E: write {in_data, in_attr} at cursor; col+1. If col was COLS-1: col=0 and perform line advance.
  - 0x0D CR: col=0.
  - 0x0A LF: line advance.
  - 0x08 BS: col-1 if col>0, else no change (no reverse wrap).
  - 0x09 TAB: col = next multiple of 8; if ≥COLS, col=COLS-1.
  - 0x0C FF: enter CLEAR.
  - all other bytes: consumed, no effect.
- Line advance: if row<ROWS-1, row+1. Else top_row = (top_row+1) mod ROWS, row stays ROWS-1, enter SCROLL.
- SCROLL: writes COLS entries {0x20, last accepted in_attr} to the new bottom row (physical row = old top_row), col 0..COLS-1 in order, then IDLE.
- CLEAR: writes ROWS*COLS entries {0x20, ATTR reset value 0x0000FFF: white fg, black bg, no underline} at addresses 0..ROWS*COLS-1 in order; on entry row=col=0, top_row=0; then IDLE.
- Blink: counter counts to BLINK_DIV-1, toggles cursor_on. Any cursor movement reloads counter and forces cursor_on=1.

## Timing
- Reset (async assert): cur_row=0, cur_col=0, top_row=0, wr_en=0, wr_addr=0, wr_char=0x20, wr_attr=0x0000FFF, cursor_on=1, in_ready=0, state=CLEAR.
- After rst_n deasserts: CLEAR writes one address per cycle, ROWS*COLS cycles; in_ready rises the cycle after the last write.
- Printable accepted at edge N: wr_en=1 during cycle N+1 with pre-advance address; cur_col/cur_row updated at N+1; next byte may be accepted at N+1 (throughput 1 byte/cycle).
- Control bytes: cursor registers update at N+1, wr_en stays 0.
- Scroll triggered at N: top_row updated at N+1; in_ready=0 from N+1; SCROLL writes occupy cycles N+2..N+COLS+1 (printable case: the character write is N+1); in_ready=1 at N+COLS+2.
- FF accepted at N: CLEAR writes cycles N+1..N+ROWS*COLS; in_ready=1 at N+ROWS*COLS+1.
- wr_en is a single-cycle pulse per address; never asserted in IDLE without an accepted printable.
- Reset mid-SCROLL/CLEAR: abandon operation, apply reset values, restart full CLEAR.
- in_valid while in_ready=0: byte held by source, not lost, not consumed.

## Test plan
- Reset, COLS=80 ROWS=30: exactly 2400 wr_en pulses, addresses 0..2399, wr_char 0x20; in_ready rises cycle 2401.
- Send 'A','B' with attr 0x1000F00: writes addr 0 'A', addr 1 'B' on consecutive cycles; cur_col=2.
- Cursor at col 79 row 0, send 'Z': write addr 79; cur_row=1, cur_col=0; then CR,LF,BS: col=0, row=2, BS leaves col=0.
- Cursor row 29, send LF: top_row=1, 80 writes to addrs 0..79 char 0x20, in_ready low 81 cycles; next 'Q' at col 0 writes addr 2320+... = ((29+1) mod 30)*80 = addr 0.
- TAB from col 3 → col 8; TAB from col 77 → col 79.
- FF mid-screen with top_row=5: full 2400-write clear, top_row=0, cursor home; assert rst_n low during clear → outputs reset immediately, clear restarts at addr 0.
